ex_muldiv: RTL

Iterative multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline latch. It consumes the latched operands `rdat1_out`/`rdat2_out` and the muldiv opcode. It computes a 64-bit product, or a quotient/remainder pair, into the architectural HI/LO registers over a fixed number of cycles. While it runs, it holds the pipeline stalled through `busy`, which the hazard logic uses to deassert the ID/EX and upstream latch enables.

---
 rtl/ex_muldiv.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- iterative multiply/divide unit for the execute stage.
//
// Computes a 64-bit product (MULTU/MULT) or a quotient/remainder pair
// (DIVU/DIV) into the HI/LO registers.  Each op takes one radix-2 step per
// cycle for WORD_W cycles, then one sign-fix cycle.  While an op runs the
// unit raises busy so the hazard logic can stall the pipeline.
//
// Ports:
//   CLK     in   clock, rising edge
//   nRST    in   synchronous active-low reset
//   start   in   launch an op (accepted in IDLE or DONE only)
//   op      in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_val  in   multiplicand / dividend
//   rt_val  in   multiplier / divisor
//   flush   in   abort the in-flight op; HI/LO untouched, no done pulse
//   busy    out  op in progress (RUN or FIX)
//   done    out  one-cycle pulse after HI/LO were written
//   hi_out  out  HI register (product high word / remainder)
//   lo_out  out  LO register (product low word / quotient)
//
// Build option: define MULDIV_DIV_EN to include the divider.  Without it,
// only MULTU/MULT are accepted and divide requests are silently ignored.
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] rs_val,
    input  logic [WORD_W-1:0] rt_val,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi_out,
    output logic [WORD_W-1:0] lo_out
);

    localparam int ACC_W = 2 * WORD_W;
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;     // {hi, lo} working register
    logic [WORD_W-1:0]  opd_q, opd_d;     // |multiplicand| or |divisor|
    logic               neg_q_q, neg_q_d; // negate product / quotient
    logic [WORD_W-1:0]  hi_q, hi_d;
    logic [WORD_W-1:0]  lo_q, lo_d;
`ifdef MULDIV_DIV_EN
    logic               neg_a_q, neg_a_d; // dividend sign -> remainder sign
    logic               is_div_q, is_div_d;
`endif

    logic signed [WORD_W-1:0] rs_s, rt_s;
    logic                     a_neg, b_neg, accept;

    function automatic logic [WORD_W-1:0] cond_neg(input logic [WORD_W-1:0] v,
                                                   input logic neg);
        return neg ? (~v + WORD_W'(1)) : v;
    endfunction

    function automatic logic [ACC_W-1:0] cond_neg2(input logic [ACC_W-1:0] v,
                                                   input logic neg);
        return neg ? (~v + ACC_W'(1)) : v;
    endfunction

    // Shift-add: multiplier sits in the low half and is consumed LSB first;
    // the carry out of the add becomes the new MSB as everything shifts right.
    function automatic logic [ACC_W-1:0] mul_step(input logic [ACC_W-1:0] acc,
                                                  input logic [WORD_W-1:0] b);
        logic [WORD_W:0] sum;
        sum = {1'b0, acc[ACC_W-1:WORD_W]} + (acc[0] ? {1'b0, b} : '0);
        return {sum, acc[WORD_W-1:1]};
    endfunction

`ifdef MULDIV_DIV_EN
    // Restoring division: trial-subtract the divisor from the shifted
    // remainder (WORD_W+1 bits, so the borrow is the MSB).  A zero divisor
    // always succeeds, giving quotient all-ones and remainder = dividend.
    function automatic logic [ACC_W-1:0] div_step(input logic [ACC_W-1:0] acc,
                                                  input logic [WORD_W-1:0] b);
        logic [WORD_W:0] trial;
        trial = acc[ACC_W-1:WORD_W-1] - {1'b0, b};
        if (!trial[WORD_W])
            return {trial[WORD_W-1:0], acc[WORD_W-2:0], 1'b1};
        else
            return {acc[ACC_W-2:0], 1'b0};
    endfunction
`endif

    assign rs_s  = rs_val;
    assign rt_s  = rt_val;
    assign a_neg = op[0] && (rs_s < 0);
    assign b_neg = op[0] && (rt_s < 0);

`ifdef MULDIV_DIV_EN
    assign accept = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));
`else
    assign accept = start && !flush && !op[1] &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_q_d = neg_q_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        neg_a_d  = neg_a_q;
        is_div_d = is_div_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        acc_d   = {{WORD_W{1'b0}}, cond_neg(rs_val, a_neg)};
                        opd_d   = cond_neg(rt_val, b_neg);
                        // A zero divisor keeps the all-ones quotient unsigned;
                        // for multiply a zero product is unaffected either way.
                        neg_q_d = (a_neg ^ b_neg) && (rt_val != '0);
`ifdef MULDIV_DIV_EN
                        neg_a_d  = a_neg;
                        is_div_d = op[1];
`endif
                    end
                end
                S_RUN: begin
`ifdef MULDIV_DIV_EN
                    acc_d = is_div_q ? div_step(acc_q, opd_q) : mul_step(acc_q, opd_q);
`else
                    acc_d = mul_step(acc_q, opd_q);
`endif
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST)
                        state_d = S_FIX;
                end
                S_FIX: begin
                    {hi_d, lo_d} = cond_neg2(acc_q, neg_q_q);
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        lo_d = cond_neg(acc_q[WORD_W-1:0], neg_q_q);
                        hi_d = cond_neg(acc_q[ACC_W-1:WORD_W], neg_a_q);
                    end
`endif
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control and architectural registers: reset to a clean idle state.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Working datapath: always reloaded on accept, so no reset needed.
    always_ff @(posedge CLK) begin
        acc_q   <= acc_d;
        opd_q   <= opd_d;
        neg_q_q <= neg_q_d;
`ifdef MULDIV_DIV_EN
        neg_a_q  <= neg_a_d;
        is_div_q <= is_div_d;
`endif
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
